branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  EX-stage resolution end of conditional-branch prediction. Carries each branch's IF-stage prediction through ID to EX and compares it with the true rs1/rs2 outcome.
//  On a mismatch it drives pipeline flush, redirect PC, predictor rollback/correction fields and RAS undo, and keeps performance counters.
//  Sits beside the branch predictor; its outputs feed the predictor's *_branch_failed / *_id / PL_flush inputs.
// PARAMETERS
//  CNT_WIDTH   32  width of branch_cnt / mispred_cnt (saturating)
//  BR_TYPES    6   one-hot branch-type vector width, bit order {bgeu,bltu,bge,blt,bne,beq}
// PORTS
//  clk              in  1          clock
//  rst_n            in  1          synchronous reset, active-low
//  PL_stall         in  1          freeze IF->ID->EX tracking registers; blocks resolution
//  if_valid         in  1          IF slot holds a real instruction
//  br_type_if       in  BR_TYPES   one-hot branch type at IF (0 = not a branch)
//  pred_taken_if    in  1          predictor result for IF branch
//  pc_if            in  32         IF pc
//  imme_if          in  32         B-type immediate, sign-extended
//  ras_push_id      in  1          ID instr pushed RAS this cycle
//  ras_pop_id       in  1          ID instr popped RAS this cycle
//  rs1_ex, rs2_ex   in  32         forwarded EX operands
//  PL_flush         out 1          kill IF and ID; fetch from redirect_pc
//  redirect_pc      out 32         correct next pc on flush
//  br_type_id       out BR_TYPES   branch type of ID slot (0 if bubble)
//  pc_id            out 32         ID pc
//  br_type_failed   out BR_TYPES   EX branch type, nonzero only when PL_flush
//  pc_branch_failed out 32         pc of mispredicted branch
//  result_failed    out 1          true outcome of mispredicted branch
//  ras_rollback_push out 1         undo ID push (= PL_flush & ras_push_id)
//  ras_rollback_pop  out 1         undo ID pop  (= PL_flush & ras_pop_id)
//  branch_cnt       out CNT_WIDTH  resolved branches
//  mispred_cnt      out CNT_WIDTH  mispredicted branches
// BEHAVIOUR
//  Reset: all tracking regs, valids, counters = 0; FSM = RUN; all outputs 0.
//  Tracking: two stages (ID, EX) of {valid, br_type, pred_taken, pc, imme}.
//    Advance only when !PL_stall. If PL_flush, ID and EX valids load 0 at that edge.
//    Flush outranks stall.
//  Resolve (combinational, EX): res_en = ex_valid & |br_type_ex & !PL_stall & state==RUN.
//    eq = rs1==rs2; lt = $signed(rs1)<$signed(rs2); ltu = rs1<rs2.
//    taken = beq:eq | bne:!eq | blt:lt | bge:!lt | bltu:ltu | bgeu:!ltu.
//    mispred = res_en & (taken != pred_taken_ex); PL_flush = mispred (same cycle, 0 latency).
//  redirect_pc = taken ? pc_ex+imme_ex : pc_ex+4, mod 2^32 wrap; 0 when !PL_flush.
//  br_type_failed/pc_branch_failed/result_failed: EX values when PL_flush, else 0.
//  br_type_id/pc_id reflect the ID slot regardless of flush. Predictor gates rollback with PL_flush.
//  FSM RUN->RECOVER on PL_flush; RECOVER->RUN next cycle unconditionally.
//    RECOVER: EX holds a bubble, no resolution, PL_flush = 0 (no back-to-back flush).
//  Counters: on res_en, branch_cnt += 1; on mispred, mispred_cnt += 1. Both saturate at all-ones.
//  Stall with mispredicting branch in EX: no flush and no count until the stall drops; exactly one flush per branch.
//  Reset mid-flush: the reset edge clears everything; no flush in the following cycle.
// STRUCTURE
//  Shared package (`define.v` section or bp_pkg): branch-type bit indices, BR_TYPES,
//    FSM encodings RUN=1'b0, RECOVER=1'b1.
//  Sub-module branch_cmp: rs1, rs2, br_type -> taken (pure combinational).
//  Top: tracking pipe, FSM, redirect adder, counters.
// TESTING
//  1 beq pc=0x100 imme=0x20 pred=0, rs1=rs2=5 -> EX cycle: PL_flush=1, redirect_pc=0x120,
//    br_type_failed=6'b000001, result_failed=1; mispred_cnt=1; next cycle PL_flush=0.
//  2 bltu pred=1, rs1=0xFFFFFFFF rs2=1 -> not taken, flush, redirect_pc=pc+4. Same with blt -> taken, matches, no flush.
//  3 mispredicting bne in EX with PL_stall=1 for 3 cycles -> no flush, counters frozen;
//    flush on first cycle with PL_stall=0, branch_cnt+1 once.
//  4 back-to-back mispredicting branches, flush on first -> second squashed, single flush;
//    ras_push_id=1 in flush cycle -> ras_rollback_push=1.
//  5 pc=0xFFFFFFF0 imme=0x20 taken mispredict -> redirect_pc=0x00000010 (wrap).
//  6 preload mispred_cnt=all-ones via CNT_WIDTH=4 and 16 mispredicts -> stays 4'hF;
//    rst_n=0 during flush cycle -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared branch-type indices, slot record and FSM encoding
package branch_resolver_pkg;

    localparam int BR_W = 6;

    // One-hot bit positions within br_type
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } br_state_e;

    typedef struct packed {
        logic            valid;
        logic [BR_W-1:0] br_type;
        logic            pred_taken;
        logic [31:0]     pc;
        logic [31:0]     imme;
    } br_slot_t;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - true outcome of a conditional branch from its operands and one-hot type
module branch_cmp
    import branch_resolver_pkg::*;
(
    input  logic [31:0]     rs1,
    input  logic [31:0]     rs2,
    input  logic [BR_W-1:0] br_type,
    output logic            taken
);

    logic            eq;
    logic            lt;
    logic            ltu;
    logic [BR_W-1:0] cond;

    always_comb begin
        eq  = (rs1 == rs2);
        lt  = ($signed(rs1) < $signed(rs2));
        ltu = (rs1 < rs2);

        cond          = '0;
        cond[BR_BEQ]  = eq;
        cond[BR_BNE]  = ~eq;
        cond[BR_BLT]  = lt;
        cond[BR_BGE]  = ~lt;
        cond[BR_BLTU] = ltu;
        cond[BR_BGEU] = ~ltu;

        // br_type is one-hot, so at most one condition survives the mask
        taken = |(br_type & cond);
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - carries IF predictions to EX, resolves them, drives flush/redirect/rollback
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int BR_TYPES  = BR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 PL_stall,
    input  logic                 if_valid,
    input  logic [BR_TYPES-1:0]  br_type_if,
    input  logic                 pred_taken_if,
    input  logic [31:0]          pc_if,
    input  logic [31:0]          imme_if,
    input  logic                 ras_push_id,
    input  logic                 ras_pop_id,
    input  logic [31:0]          rs1_ex,
    input  logic [31:0]          rs2_ex,
    output logic                 PL_flush,
    output logic [31:0]          redirect_pc,
    output logic [BR_TYPES-1:0]  br_type_id,
    output logic [31:0]          pc_id,
    output logic [BR_TYPES-1:0]  br_type_failed,
    output logic [31:0]          pc_branch_failed,
    output logic                 result_failed,
    output logic                 ras_rollback_push,
    output logic                 ras_rollback_pop,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    br_slot_t  id_q, id_d;
    br_slot_t  ex_q, ex_d;
    br_state_e state_q, state_d;

    logic        taken;
    logic        res_en;
    logic        mispred;
    logic [31:0] target;

    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] mispred_cnt_q;

    branch_cmp u_cmp (
        .rs1     (rs1_ex),
        .rs2     (rs2_ex),
        .br_type (ex_q.br_type),
        .taken   (taken)
    );

    // Resolution is blocked while stalled and during the recovery cycle,
    // which is what guarantees a single flush per mispredicted branch.
    always_comb begin
        res_en  = ex_q.valid & (|ex_q.br_type) & ~PL_stall & (state_q == ST_RUN);
        mispred = res_en & (taken != ex_q.pred_taken);
        target  = taken ? (ex_q.pc + ex_q.imme) : (ex_q.pc + 32'd4);
    end

    always_comb begin
        id_d            = '0;
        id_d.valid      = if_valid & ~mispred;
        id_d.br_type    = if_valid ? br_type_if : '0;
        id_d.pred_taken = pred_taken_if;
        id_d.pc         = pc_if;
        id_d.imme       = imme_if;

        ex_d       = id_q;
        ex_d.valid = id_q.valid & ~mispred;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (mispred) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q          <= '0;
            ex_q          <= '0;
            state_q       <= ST_RUN;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // A flush only arises when not stalled, but it must always land
            if (mispred || !PL_stall) begin
                id_q <= id_d;
                ex_q <= ex_d;
            end
            if (res_en && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            if (mispred && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign PL_flush          = mispred;
    assign redirect_pc       = mispred ? target : 32'd0;
    assign br_type_id        = id_q.valid ? id_q.br_type : '0;
    assign pc_id             = id_q.pc;
    assign br_type_failed    = mispred ? ex_q.br_type : '0;
    assign pc_branch_failed  = mispred ? ex_q.pc : 32'd0;
    assign result_failed     = mispred & taken;
    assign ras_rollback_push = mispred & ras_push_id;
    assign ras_rollback_pop  = mispred & ras_pop_id;
    assign branch_cnt        = branch_cnt_q;
    assign mispred_cnt       = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - table, directed and random checks of branch_resolver against a reference model
module tb_branch_resolver;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    localparam bit [5:0] T_BEQ  = 6'b000001;
    localparam bit [5:0] T_BNE  = 6'b000010;
    localparam bit [5:0] T_BLT  = 6'b000100;
    localparam bit [5:0] T_BLTU = 6'b010000;

    logic          clk = 1'b0;
    logic          rst_n, PL_stall, if_valid, pred_taken_if;
    logic [5:0]    br_type_if;
    logic [31:0]   pc_if, imme_if, rs1_ex, rs2_ex;
    logic          ras_push_id, ras_pop_id;
    logic          PL_flush, result_failed, ras_rollback_push, ras_rollback_pop;
    logic [31:0]   redirect_pc, pc_id, pc_branch_failed;
    logic [5:0]    br_type_id, br_type_failed;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    branch_resolver #(.CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .PL_stall          (PL_stall),
        .if_valid          (if_valid),
        .br_type_if        (br_type_if),
        .pred_taken_if     (pred_taken_if),
        .pc_if             (pc_if),
        .imme_if           (imme_if),
        .ras_push_id       (ras_push_id),
        .ras_pop_id        (ras_pop_id),
        .rs1_ex            (rs1_ex),
        .rs2_ex            (rs2_ex),
        .PL_flush          (PL_flush),
        .redirect_pc       (redirect_pc),
        .br_type_id        (br_type_id),
        .pc_id             (pc_id),
        .br_type_failed    (br_type_failed),
        .pc_branch_failed  (pc_branch_failed),
        .result_failed     (result_failed),
        .ras_rollback_push (ras_rollback_push),
        .ras_rollback_pop  (ras_rollback_pop),
        .branch_cnt        (branch_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        rst;
        bit        stall;
        bit        ifv;
        bit [5:0]  ty;
        bit        pred;
        bit [31:0] pc;
        bit [31:0] imm;
        bit        push;
        bit        pop;
        bit [31:0] rs1;
        bit [31:0] rs2;
        bit        exp_flush;
        bit [31:0] exp_redir;
    } vec_t;

    // Reference model: an instruction occupies ID then EX; a wrong guess flushes both
    // younger slots and forbids resolution for one cycle.
    typedef struct {
        bit        v;
        bit [5:0]  ty;
        bit        pred;
        bit [31:0] pc;
        bit [31:0] imm;
    } slot_t;

    slot_t m_id, m_ex;
    bit    m_rec;
    int    m_b, m_m;

    function automatic bit ref_taken(input bit [5:0] ty, input bit [31:0] a, input bit [31:0] b);
        if (ty[0]) return a == b;
        if (ty[1]) return a != b;
        if (ty[2]) return $signed(a) <  $signed(b);
        if (ty[3]) return $signed(a) >= $signed(b);
        if (ty[4]) return a <  b;
        if (ty[5]) return a >= b;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input bit [5:0] ty, input bit pred, input bit [31:0] pc,
                                input bit [31:0] imm, input bit [31:0] rs1, input bit [31:0] rs2,
                                input bit push, input bit ef, input bit [31:0] er);
        vec_t c;
        c.rst = 1'b1; c.stall = 1'b0; c.ifv = (ty != 0); c.ty = ty; c.pred = pred;
        c.pc = pc; c.imm = imm; c.push = push; c.pop = 1'b0; c.rs1 = rs1; c.rs2 = rs2;
        c.exp_flush = ef; c.exp_redir = er;
        return c;
    endfunction

    function automatic vec_t nop(input bit [31:0] rs1, input bit [31:0] rs2);
        return mk(6'd0, 1'b0, 32'd0, 32'd0, rs1, rs2, 1'b0, 1'b0, 32'd0);
    endfunction

    // Drive one cycle at the falling edge, check all outputs, then advance the model
    task automatic step(input vec_t c);
        bit        res, tk, mis;
        bit [31:0] tgt;
        @(negedge clk);
        rst_n = c.rst; PL_stall = c.stall; if_valid = c.ifv; br_type_if = c.ty;
        pred_taken_if = c.pred; pc_if = c.pc; imme_if = c.imm;
        ras_push_id = c.push; ras_pop_id = c.pop; rs1_ex = c.rs1; rs2_ex = c.rs2;
        #1;
        res = m_ex.v && (m_ex.ty != 0) && !c.stall && !m_rec;
        tk  = ref_taken(m_ex.ty, c.rs1, c.rs2);
        mis = res && (tk != m_ex.pred);
        tgt = tk ? m_ex.pc + m_ex.imm : m_ex.pc + 32'd4;
        chk("PL_flush",          PL_flush,          32'(mis));
        chk("redirect_pc",       redirect_pc,       mis ? tgt : 32'd0);
        chk("br_type_failed",    br_type_failed,    mis ? m_ex.ty : 6'd0);
        chk("pc_branch_failed",  pc_branch_failed,  mis ? m_ex.pc : 32'd0);
        chk("result_failed",     result_failed,     32'(mis && tk));
        chk("ras_rollback_push", ras_rollback_push, 32'(mis && c.push));
        chk("ras_rollback_pop",  ras_rollback_pop,  32'(mis && c.pop));
        chk("br_type_id",        br_type_id,        m_id.v ? m_id.ty : 6'd0);
        chk("pc_id",             pc_id,             m_id.pc);
        chk("branch_cnt",        branch_cnt,        32'(m_b));
        chk("mispred_cnt",       mispred_cnt,       32'(m_m));
        if (!c.rst) begin
            m_id = '{default: 0}; m_ex = '{default: 0};
            m_rec = 1'b0; m_b = 0; m_m = 0;
        end else begin
            if (res) m_b = (m_b == SAT) ? SAT : m_b + 1;
            if (mis) m_m = (m_m == SAT) ? SAT : m_m + 1;
            m_rec = mis;
            if (mis || !c.stall) begin
                m_ex   = m_id;
                m_ex.v = m_id.v && !mis;
                m_id.v = c.ifv && !mis; m_id.ty = c.ty; m_id.pred = c.pred;
                m_id.pc = c.pc; m_id.imm = c.imm;
            end
        end
    endtask

    task automatic do_reset();
        vec_t c;
        c = nop(32'd0, 32'd0);
        c.rst = 1'b0;
        step(c);
        step(c);
    endtask

    vec_t tbl[$];
    vec_t c;
    int   saved_b;

    initial begin
        m_id = '{default: 0}; m_ex = '{default: 0}; m_rec = 1'b0; m_b = 0; m_m = 0;

        // Directed table: one row per cycle, with the flush/redirect expected in that cycle
        tbl.push_back(mk(T_BEQ, 0, 32'h100, 32'h20, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 5, 5, 0, 1, 32'h120));
        tbl.push_back(nop(5, 5));
        tbl.push_back(mk(T_BLTU, 1, 32'h200, 32'h40, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 1, 32'h204));
        tbl.push_back(mk(T_BLT, 1, 32'h300, 32'h40, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(T_BNE, 0, 32'h400, 32'h8, 0, 0, 0, 0, 0));
        tbl.push_back(mk(T_BEQ, 0, 32'h404, 32'h10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 32'h408));
        tbl.push_back(nop(3, 3));
        tbl.push_back(nop(3, 3));
        tbl.push_back(mk(T_BEQ, 0, 32'hFFFFFFF0, 32'h20, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 7, 7, 0, 1, 32'h10));
        tbl.push_back(nop(0, 0));

        do_reset();
        chk("reset_flush", PL_flush, 32'd0);
        chk("reset_branch_cnt", branch_cnt, 32'd0);
        chk("reset_br_type_id", br_type_id, 32'd0);

        foreach (tbl[i]) begin
            step(tbl[i]);
            chk($sformatf("tbl%0d_flush", i), PL_flush, 32'(tbl[i].exp_flush));
            chk($sformatf("tbl%0d_redirect", i), redirect_pc, tbl[i].exp_redir);
            if (tbl[i].push) chk($sformatf("tbl%0d_rollback_push", i), ras_rollback_push, 32'(tbl[i].exp_flush));
        end

        // Mispredicting bne held in EX by a three-cycle stall
        do_reset();
        step(mk(T_BNE, 0, 32'h500, 32'h10, 0, 0, 0, 0, 0));
        step(nop(0, 0));
        for (int k = 0; k < 3; k++) begin
            c = nop(1, 2);
            c.stall = 1'b1;
            step(c);
            chk("stall_no_flush", PL_flush, 32'd0);
            chk("stall_branch_cnt", branch_cnt, 32'd0);
        end
        step(nop(1, 2));
        chk("unstall_flush", PL_flush, 32'd1);
        chk("unstall_redirect", redirect_pc, 32'h510);
        step(nop(1, 2));
        chk("unstall_branch_cnt", branch_cnt, 32'd1);
        chk("unstall_mispred_cnt", mispred_cnt, 32'd1);
        chk("unstall_single_flush", PL_flush, 32'd0);
        step(nop(1, 2));
        chk("unstall_branch_cnt_once", branch_cnt, 32'd1);

        // Counter saturation, then reset asserted in a flush cycle
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step(mk(T_BEQ, 0, 32'h1000 + 32'(k * 4), 32'h20, 0, 0, 0, 0, 0));
            step(nop(0, 0));
            step(nop(5, 5));
            step(nop(0, 0));
        end
        chk("sat_mispred_cnt", mispred_cnt, 32'hF);
        chk("sat_branch_cnt", branch_cnt, 32'hF);
        step(mk(T_BEQ, 0, 32'h2000, 32'h20, 0, 0, 0, 0, 0));
        step(nop(0, 0));
        c = nop(5, 5);
        c.rst = 1'b0;
        step(c);
        chk("rstflush_flush_before_edge", PL_flush, 32'd1);
        step(nop(5, 5));
        chk("rstflush_flush", PL_flush, 32'd0);
        chk("rstflush_redirect", redirect_pc, 32'd0);
        chk("rstflush_mispred_cnt", mispred_cnt, 32'd0);
        chk("rstflush_pc_id", pc_id, 32'd0);

        // Randomized traffic against the model
        begin
            bit [31:0] ops[6];
            ops[0] = 32'd0; ops[1] = 32'd1; ops[2] = 32'hFFFFFFFF;
            ops[3] = 32'h80000000; ops[4] = 32'h7FFFFFFF; ops[5] = 32'd5;
            for (int k = 0; k < 600; k++) begin
                c = nop(0, 0);
                c.rst   = ($urandom_range(0, 99) != 0);
                c.stall = ($urandom_range(0, 4) == 0);
                c.ifv   = $urandom_range(0, 3) != 0;
                c.ty    = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'(1 << $urandom_range(0, 5));
                c.pred  = 1'($urandom_range(0, 1));
                c.pc    = $urandom() & 32'hFFFFFFFC;
                c.imm   = 32'($signed(12'($urandom()))) & 32'hFFFFFFFE;
                c.push  = 1'($urandom_range(0, 1));
                c.pop   = 1'($urandom_range(0, 1));
                c.rs1   = ($urandom_range(0, 3) == 0) ? $urandom() : ops[$urandom_range(0, 5)];
                c.rs2   = ($urandom_range(0, 3) == 0) ? c.rs1 : ops[$urandom_range(0, 5)];
                step(c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
